alu_decode_stage: RTL and testbench

ALU_DECODE_STAGE -- requirements
Module: alu_decode_stage

---
 rtl/alu_decode_pkg.sv | 45 ++++
 rtl/alu_decode_fifo.sv | 56 +++++
 rtl/alu_decode_stage.sv | 132 +++++++++++++
 tb/tb_alu_decode_stage.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_decode_pkg.sv
// Shared constants and payload type for the ALU decode stage.
package alu_decode_pkg;

  // Internal ALU operation codes (0 = no operation / illegal)
  localparam logic [5:0] ALU_NONE = 6'd0;
  localparam logic [5:0] ALU_ADDI = 6'd5;
  localparam logic [5:0] ALU_SLLI = 6'd6;
  localparam logic [5:0] ALU_SLTI = 6'd7;
  localparam logic [5:0] ALU_SLTIU = 6'd8;
  localparam logic [5:0] ALU_XORI = 6'd9;
  localparam logic [5:0] ALU_SRLI = 6'd10;
  localparam logic [5:0] ALU_SRAI = 6'd11;
  localparam logic [5:0] ALU_ORI = 6'd12;
  localparam logic [5:0] ALU_ANDI = 6'd13;
  localparam logic [5:0] ALU_ADD = 6'd18;
  localparam logic [5:0] ALU_SUB = 6'd19;
  localparam logic [5:0] ALU_SLL = 6'd20;
  localparam logic [5:0] ALU_SLT = 6'd21;
  localparam logic [5:0] ALU_SLTU = 6'd22;
  localparam logic [5:0] ALU_XOR = 6'd23;
  localparam logic [5:0] ALU_SRL = 6'd24;
  localparam logic [5:0] ALU_SRA = 6'd25;
  localparam logic [5:0] ALU_OR = 6'd26;
  localparam logic [5:0] ALU_AND = 6'd27;

  // RV32 major opcodes handled here
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP = 7'b0110011;

  // funct7 encodings
  localparam logic [6:0] F7_ZERO = 7'b0000000;
  localparam logic [6:0] F7_ALT = 7'b0100000;

  // Decoded beat carried through the FIFO
  typedef struct packed {
    logic [5:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic        illegal;
  } dec_t;

  localparam int DEC_W = $bits(dec_t);

endpackage

// File: rtl/alu_decode_fifo.sv
// Two-entry FIFO with registered ready; head register holds its value when empty.
module alu_decode_fifo #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_valid,
  output logic         o_ready,
  input  logic [W-1:0] i_data,
  output logic         o_valid,
  input  logic         i_ready,
  output logic [W-1:0] o_data
);

  logic [1:0]   r_cnt;
  logic         r_ready;
  logic [W-1:0] r_d0;
  logic [W-1:0] r_d1;
  logic         w_push;
  logic         w_pop;
  logic [1:0]   w_cnt_nxt;

  assign w_push  = i_valid && r_ready;
  assign w_pop   = (r_cnt != 2'd0) && i_ready;
  assign o_ready = r_ready;
  assign o_valid = (r_cnt != 2'd0);
  assign o_data  = r_d0;

  // Next occupancy from push/pop of this cycle
  always_comb begin
    w_cnt_nxt = r_cnt;
    if (w_push && !w_pop)      w_cnt_nxt = r_cnt + 2'd1;
    else if (!w_push && w_pop) w_cnt_nxt = r_cnt - 2'd1;
  end

  // Occupancy, registered ready and storage; r_d0 is the head and is only
  // rewritten by a new beat or a shift from r_d1, so it keeps the last popped value
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt   <= 2'd0;
      r_ready <= 1'b0;
      r_d0    <= '0;
      r_d1    <= '0;
    end else begin
      r_cnt   <= w_cnt_nxt;
      r_ready <= (w_cnt_nxt < 2'd2);
      if (w_push && ((r_cnt == 2'd0) || ((r_cnt == 2'd1) && w_pop)))
        r_d0 <= i_data;
      else if (w_pop && (r_cnt == 2'd2))
        r_d0 <= r_d1;
      if (w_push && (r_cnt == 2'd1) && !w_pop)
        r_d1 <= i_data;
    end
  end

endmodule

// File: rtl/alu_decode_stage.sv
// RV32 OP/OP-IMM decode into ALU opcode and operands, buffered by a 2-entry FIFO.
module alu_decode_stage
  import alu_decode_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      instr,
  input  logic [31:0]      rs1_data,
  input  logic [31:0]      rs2_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [5:0]       alu_opcode,
  output logic [31:0]      operand_a,
  output logic [31:0]      operand_b,
  output logic [4:0]       rd,
  output logic             illegal,
  output logic [CNT_W-1:0] illegal_cnt
);

  logic [6:0]       w_opc;
  logic [2:0]       w_f3;
  logic [6:0]       w_f7;
  logic [5:0]       w_op;
  logic [31:0]      w_b;
  logic             w_legal;
  dec_t             w_dec;
  dec_t             w_head;
  logic             w_in_fire;
  logic             w_unused;
  logic [CNT_W-1:0] r_ill_cnt;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign w_opc     = instr[6:0];
  assign w_f3      = instr[14:12];
  assign w_f7      = instr[31:25];
  assign w_unused  = ^instr[19:15];
  assign w_in_fire = in_valid && in_ready;

  // Combinational decode of the incoming instruction
  always_comb begin
    w_op    = ALU_NONE;
    w_b     = rs2_data;
    w_legal = 1'b0;
    case (w_opc)
      OPC_OP_IMM: begin
        w_b     = {{20{instr[31]}}, instr[31:20]};
        w_legal = 1'b1;
        case (w_f3)
          3'b000: w_op = ALU_ADDI;
          3'b001: begin
            w_op    = ALU_SLLI;
            w_b     = {27'd0, instr[24:20]};
            w_legal = (w_f7 == F7_ZERO);
          end
          3'b010: w_op = ALU_SLTI;
          3'b011: w_op = ALU_SLTIU;
          3'b100: w_op = ALU_XORI;
          3'b101: begin
            w_b = {27'd0, instr[24:20]};
            if (w_f7 == F7_ZERO)     w_op = ALU_SRLI;
            else if (w_f7 == F7_ALT) w_op = ALU_SRAI;
            else                     w_legal = 1'b0;
          end
          3'b110: w_op = ALU_ORI;
          default: w_op = ALU_ANDI;
        endcase
      end
      OPC_OP: begin
        w_legal = 1'b1;
        if (w_f7 == F7_ZERO) begin
          case (w_f3)
            3'b000: w_op = ALU_ADD;
            3'b001: w_op = ALU_SLL;
            3'b010: w_op = ALU_SLT;
            3'b011: w_op = ALU_SLTU;
            3'b100: w_op = ALU_XOR;
            3'b101: w_op = ALU_SRL;
            3'b110: w_op = ALU_OR;
            default: w_op = ALU_AND;
          endcase
        end else if ((w_f7 == F7_ALT) && (w_f3 == 3'b000)) begin
          w_op = ALU_SUB;
        end else if ((w_f7 == F7_ALT) && (w_f3 == 3'b101)) begin
          w_op = ALU_SRA;
        end else begin
          w_legal = 1'b0;
        end
      end
      default: w_legal = 1'b0;
    endcase
  end

  // Illegal beats carry an all-zero payload with only the illegal flag set
  assign w_dec = w_legal ? '{op: w_op, a: rs1_data, b: w_b, rd: instr[11:7], illegal: 1'b0}
                         : '{op: ALU_NONE, a: 32'd0, b: 32'd0, rd: 5'd0, illegal: 1'b1};

  alu_decode_fifo #(
    .W(DEC_W)
  ) u_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_valid(in_valid),
    .o_ready(in_ready),
    .i_data (w_dec),
    .o_valid(out_valid),
    .i_ready(out_ready),
    .o_data (w_head)
  );

  assign alu_opcode  = w_head.op;
  assign operand_a   = w_head.a;
  assign operand_b   = w_head.b;
  assign rd          = w_head.rd;
  assign illegal     = w_head.illegal;
  assign illegal_cnt = r_ill_cnt;

  // Saturating count of accepted illegal beats
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_ill_cnt <= '0;
    else if (w_in_fire && w_dec.illegal)
      r_ill_cnt <= sat_inc(r_ill_cnt);
  end

endmodule

// File: tb/tb_alu_decode_stage.sv
// Directed testbench for alu_decode_stage.
module tb_alu_decode_stage;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instr;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic        out_valid;
  logic        out_ready;
  logic [5:0]  alu_opcode;
  logic [31:0] operand_a;
  logic [31:0] operand_b;
  logic [4:0]  rd;
  logic        illegal;
  logic [15:0] illegal_cnt;

  logic        in_ready2;
  logic        out_valid2;
  logic [5:0]  alu_opcode2;
  logic [31:0] operand_a2;
  logic [31:0] operand_b2;
  logic [4:0]  rd2;
  logic        illegal2;
  logic [1:0]  illegal_cnt2;

  int n_vec;
  int n_err;

  alu_decode_stage dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .out_valid(out_valid), .out_ready(out_ready), .alu_opcode(alu_opcode),
    .operand_a(operand_a), .operand_b(operand_b), .rd(rd),
    .illegal(illegal), .illegal_cnt(illegal_cnt)
  );

  alu_decode_stage #(.CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2),
    .instr(instr), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .out_valid(out_valid2), .out_ready(out_ready), .alu_opcode(alu_opcode2),
    .operand_a(operand_a2), .operand_b(operand_b2), .rd(rd2),
    .illegal(illegal2), .illegal_cnt(illegal_cnt2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present one beat for one clock edge, return at edge + 1
  task automatic put(input logic [31:0] i, input logic [31:0] a, input logic [31:0] b);
    in_valid = 1'b1;
    instr    = i;
    rs1_data = a;
    rs2_data = b;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    instr = 32'd0; rs1_data = 32'd0; rs2_data = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    n_vec++;
    if ({out_valid, in_ready, alu_opcode, operand_a, operand_b, rd, illegal, illegal_cnt} !== '0) begin
      n_err++;
      $display("FAIL reset_state: ov=%b ir=%b op=%0d a=%h b=%h rd=%0d ill=%b cnt=%0d, required all zero",
               out_valid, in_ready, alu_opcode, operand_a, operand_b, rd, illegal, illegal_cnt);
    end
    rst_n = 1'b1;
    #1;
    n_vec++;
    if (in_ready !== 1'b0) begin
      n_err++;
      $display("FAIL ready_before_edge: in_ready=%b, required 0", in_ready);
    end
    @(posedge clk);
    #1;
    n_vec++;
    if (in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL ready_after_edge: in_ready=%b, required 1", in_ready);
    end
  endtask

  task automatic test_itype();
    logic [31:0] ti [6] = '{32'hFFF10093, 32'h40335293, 32'h01F41393, 32'h7FF24213, 32'h8000F513, 32'h0041D113};
    logic [31:0] ta [6] = '{32'd5, 32'h80000000, 32'h1234, 32'hA5, 32'd1, 32'hF0};
    logic [5:0]  to [6] = '{6'd5, 6'd11, 6'd6, 6'd9, 6'd13, 6'd10};
    logic [31:0] tb [6] = '{32'hFFFFFFFF, 32'd3, 32'd31, 32'h7FF, 32'hFFFFF800, 32'd4};
    logic [4:0]  tr [6] = '{5'd1, 5'd5, 5'd7, 5'd4, 5'd10, 5'd2};
    out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      put(ti[k], ta[k], 32'h5555AAAA);
      n_vec++;
      if ({out_valid, alu_opcode, operand_a, operand_b, rd, illegal} !== {1'b1, to[k], ta[k], tb[k], tr[k], 1'b0}) begin
        n_err++;
        $display("FAIL itype[%0d]: ov=%b op=%0d a=%h b=%h rd=%0d ill=%b, required ov=1 op=%0d a=%h b=%h rd=%0d ill=0",
                 k, out_valid, alu_opcode, operand_a, operand_b, rd, illegal, to[k], ta[k], tb[k], tr[k]);
      end
    end
  endtask

  task automatic test_rtype();
    logic [31:0] ti [5] = '{32'h402081B3, 32'h007302B3, 32'h40A4D433, 32'h01DF7FB3, 32'h003120B3};
    logic [31:0] ta [5] = '{32'd9, 32'd1, 32'h80000000, 32'hFF, 32'hFFFFFFFE};
    logic [31:0] tb [5] = '{32'd4, 32'd2, 32'd7, 32'h0F, 32'd3};
    logic [5:0]  to [5] = '{6'd19, 6'd18, 6'd25, 6'd27, 6'd21};
    logic [4:0]  tr [5] = '{5'd3, 5'd5, 5'd8, 5'd31, 5'd1};
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      put(ti[k], ta[k], tb[k]);
      n_vec++;
      if ({out_valid, alu_opcode, operand_a, operand_b, rd, illegal} !== {1'b1, to[k], ta[k], tb[k], tr[k], 1'b0}) begin
        n_err++;
        $display("FAIL rtype[%0d]: ov=%b op=%0d a=%h b=%h rd=%0d ill=%b, required ov=1 op=%0d a=%h b=%h rd=%0d ill=0",
                 k, out_valid, alu_opcode, operand_a, operand_b, rd, illegal, to[k], ta[k], tb[k], tr[k]);
      end
    end
  endtask

  task automatic test_illegal();
    logic [31:0] ti [6] = '{32'h0000006F, 32'h03F41393, 32'h023100B3, 32'h402091B3, 32'h42335293, 32'h000000B7};
    out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      put(ti[k], 32'hDEAD, 32'hBEEF);
      n_vec++;
      if ({out_valid, alu_opcode, operand_a, operand_b, rd, illegal, illegal_cnt} !==
          {1'b1, 6'd0, 32'd0, 32'd0, 5'd0, 1'b1, 16'(k + 1)}) begin
        n_err++;
        $display("FAIL illegal[%0d]: ov=%b op=%0d a=%h b=%h rd=%0d ill=%b cnt=%0d, required ov=1 zeros ill=1 cnt=%0d",
                 k, out_valid, alu_opcode, operand_a, operand_b, rd, illegal, illegal_cnt, k + 1);
      end
    end
  endtask

  task automatic test_throughput_hold();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      instr    = (32'(k) << 7) | 32'h13;
      rs1_data = 32'(k * 3);
      @(posedge clk);
      #1;
      n_vec++;
      if ({out_valid, in_ready, alu_opcode, operand_a, rd} !== {1'b1, 1'b1, 6'd5, 32'(k * 3), 5'(k)}) begin
        n_err++;
        $display("FAIL throughput[%0d]: ov=%b ir=%b op=%0d a=%h rd=%0d, required ov=1 ir=1 op=5 a=%h rd=%0d",
                 k, out_valid, in_ready, alu_opcode, operand_a, rd, k * 3, k);
      end
    end
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    n_vec++;
    if ({out_valid, alu_opcode, operand_a, rd} !== {1'b0, 6'd5, 32'd12, 5'd4}) begin
      n_err++;
      $display("FAIL hold_after_pop: ov=%b op=%0d a=%h rd=%0d, required ov=0 op=5 a=c rd=4",
               out_valid, alu_opcode, operand_a, rd);
    end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    instr = 32'hFFF10093; rs1_data = 32'd5;
    @(posedge clk); #1;
    instr = 32'h402081B3; rs1_data = 32'd9; rs2_data = 32'd4;
    @(posedge clk); #1;
    instr = 32'h007302B3; rs1_data = 32'd1; rs2_data = 32'd2;
    n_vec++;
    if ({in_ready, out_valid, alu_opcode, rd} !== {1'b0, 1'b1, 6'd5, 5'd1}) begin
      n_err++;
      $display("FAIL b2b_full: ir=%b ov=%b op=%0d rd=%0d, required ir=0 ov=1 op=5 rd=1",
               in_ready, out_valid, alu_opcode, rd);
    end
    @(posedge clk); #1;
    n_vec++;
    if ({in_ready, out_valid, alu_opcode, operand_a, operand_b, rd} !== {1'b0, 1'b1, 6'd5, 32'd5, 32'hFFFFFFFF, 5'd1}) begin
      n_err++;
      $display("FAIL b2b_stall: ir=%b ov=%b op=%0d a=%h b=%h rd=%0d, required ir=0 ov=1 op=5 a=5 b=ffffffff rd=1",
               in_ready, out_valid, alu_opcode, operand_a, operand_b, rd);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    n_vec++;
    if ({out_valid, alu_opcode, operand_a, rd} !== {1'b1, 6'd19, 32'd9, 5'd3}) begin
      n_err++;
      $display("FAIL b2b_second: ov=%b op=%0d a=%h rd=%0d, required ov=1 op=19 a=9 rd=3",
               out_valid, alu_opcode, operand_a, rd);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    n_vec++;
    if ({out_valid, alu_opcode, operand_a, rd} !== {1'b1, 6'd18, 32'd1, 5'd5}) begin
      n_err++;
      $display("FAIL b2b_third: ov=%b op=%0d a=%h rd=%0d, required ov=1 op=18 a=1 rd=5",
               out_valid, alu_opcode, operand_a, rd);
    end
    @(posedge clk); #1;
    n_vec++;
    if ({out_valid, in_ready, rd} !== {1'b0, 1'b1, 5'd5}) begin
      n_err++;
      $display("FAIL b2b_drain: ov=%b ir=%b rd=%0d, required ov=0 ir=1 rd=5", out_valid, in_ready, rd);
    end
  endtask

  task automatic test_reset_flush();
    out_ready = 1'b0;
    put(32'hFFF10093, 32'd5, 32'd0);
    put(32'h40335293, 32'h80000000, 32'd0);
    rst_n = 1'b0;
    #1;
    n_vec++;
    if ({out_valid, in_ready, alu_opcode, rd, illegal_cnt} !== '0) begin
      n_err++;
      $display("FAIL flush_async: ov=%b ir=%b op=%0d rd=%0d cnt=%0d, required all zero",
               out_valid, in_ready, alu_opcode, rd, illegal_cnt);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      n_vec++;
      if ({out_valid, in_ready} !== 2'b01) begin
        n_err++;
        $display("FAIL flush_stale[%0d]: ov=%b ir=%b, required ov=0 ir=1", k, out_valid, in_ready);
      end
    end
  endtask

  task automatic test_saturate();
    out_ready = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      put(32'h0000006F, 32'd0, 32'd0);
      n_vec++;
      if ({illegal_cnt, illegal_cnt2} !== {16'(k), (k >= 3) ? 2'd3 : 2'(k)}) begin
        n_err++;
        $display("FAIL saturate[%0d]: cnt16=%0d cnt2=%0d, required cnt16=%0d cnt2=%0d",
                 k, illegal_cnt, illegal_cnt2, k, (k >= 3) ? 3 : k);
      end
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    test_reset();
    test_itype();
    test_rtype();
    test_illegal();
    test_throughput_hold();
    test_back_to_back();
    test_reset_flush();
    test_saturate();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
